burst_feeder: RTL and testbench

Stimulus-side partner for the team's 8-sample byte accumulator. It collects eight bytes from a host write port and streams them out as one `go_out`/`d_out` burst. It then waits for the accumulator's `valid_in`/`data_in` result and checks that result against its own expected 11-bit sum. It sits between a host or bench sequencer and the accumulator, and serves as both traffic source and self-checking scoreboard.

---
 rtl/burst_feeder_pkg.sv | 15 +
 rtl/burst_feeder_buf.sv | 22 ++
 rtl/burst_feeder.sv | 155 +++++++++++++++
 tb/tb_burst_feeder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/burst_feeder_pkg.sv
// Shared types and default sizes for the burst feeder and its buffer.
package burst_feeder_pkg;
  localparam int DW_DEF      = 8;
  localparam int N_DEF       = 8;
  localparam int SW_DEF      = 11;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = $clog2(N_DEF);
  localparam int TMR_W       = $clog2(TIMEOUT_DEF);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;
endpackage

// File: rtl/burst_feeder_buf.sv
// N x DW register file: synchronous write, combinational read.
module burst_buf #(
  parameter int DW = 8,
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [N-1:0][DW-1:0] mem_q;

  // Contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/burst_feeder.sv
// Collects N host bytes, streams them as one burst, then checks the
// accumulator's returned sum against the locally accumulated one.
module burst_feeder
  import burst_feeder_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int N       = N_DEF,
  parameter int SW      = SW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          go_out,
  output logic [DW-1:0] d_out,
  input  logic          valid_in,
  input  logic [SW-1:0] data_in,
  output logic          busy,
  output logic          done,
  output logic          match,
  output logic          timeout
);
  localparam int CW = $clog2(N);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW:0]   rd_cnt_q, rd_cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [SW-1:0] exp_q, exp_d;
  logic          wr_ready_q, wr_ready_d;
  logic          go_q, go_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          match_q, match_d;
  logic          to_q, to_d;

  logic          buf_we;
  logic [CW-1:0] raddr;
  logic [DW-1:0] rdata;

  burst_buf #(.DW(DW), .N(N), .AW(CW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_cnt_q),
    .wdata (wr_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    tmr_d    = tmr_q;
    exp_d    = exp_q;
    go_d     = 1'b0;
    dout_d   = '0;
    done_d   = 1'b0;
    match_d  = match_q;
    to_d     = to_q;
    buf_we   = 1'b0;
    raddr    = rd_cnt_q[CW-1:0];
    case (state_q)
      FILL: begin
        // Preload buf[0] so the first burst byte leaves on the edge after the last write.
        raddr = '0;
        if (wr_en) begin
          buf_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + CW'(1);
          exp_d    = exp_q + SW'(wr_data);
          if (wr_cnt_q == CW'(N-1)) begin
            state_d  = SEND;
            wr_cnt_d = '0;
            go_d     = 1'b1;
            dout_d   = rdata;
            rd_cnt_d = (CW+1)'(1);
          end
        end
      end
      SEND: begin
        if (rd_cnt_q == (CW+1)'(N)) begin
          state_d  = WAIT;
          tmr_d    = '0;
          rd_cnt_d = '0;
        end else begin
          go_d     = 1'b1;
          dout_d   = rdata;
          rd_cnt_d = rd_cnt_q + (CW+1)'(1);
        end
      end
      WAIT: begin
        tmr_d = tmr_q + TW'(1);
        if (valid_in) begin
          match_d = (data_in == exp_q);
          to_d    = 1'b0;
          done_d  = 1'b1;
          exp_d   = '0;
          state_d = FILL;
        end else if (tmr_q == TW'(TIMEOUT-1)) begin
          // Also drop the sum so the next burst starts from zero.
          match_d = 1'b0;
          to_d    = 1'b1;
          done_d  = 1'b1;
          exp_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    wr_ready_d = (state_d == FILL);
    busy_d     = (state_d != FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      tmr_q      <= '0;
      exp_q      <= '0;
      wr_ready_q <= 1'b1;
      go_q       <= 1'b0;
      dout_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      tmr_q      <= tmr_d;
      exp_q      <= exp_d;
      wr_ready_q <= wr_ready_d;
      go_q       <= go_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      match_q    <= match_d;
      to_q       <= to_d;
    end
  end

  assign wr_ready = wr_ready_q;
  assign go_out   = go_q;
  assign d_out    = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign match    = match_q;
  assign timeout  = to_q;
endmodule

// File: tb/tb_burst_feeder.sv
// Directed, table-driven bench for burst_feeder with hand-computed sums.
module tb_burst_feeder;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        go_out;
  logic [7:0]  d_out;
  logic        valid_in;
  logic [10:0] data_in;
  logic        busy;
  logic        done;
  logic        match;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  burst_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .go_out   (go_out),
    .d_out    (d_out),
    .valid_in (valid_in),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .match    (match),
    .timeout  (timeout)
  );

  typedef struct {
    logic [7:0][7:0] b;
    int              gap;
    logic            abuse_wr;
    logic            abuse_vld;
    int              dly;        // -1: never return a result
    logic [10:0]     res;
    logic            exp_match;
    logic            exp_to;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [7:0][7:0] pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][7:0] r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic write_burst(input logic [7:0][7:0] b, input int gap, input logic abuse_vld,
                             input logic [10:0] vres);
    for (int i = 0; i < 8; i++) begin
      check("wr_ready_fill", wr_ready, 1);
      wr_en    = 1'b1;
      wr_data  = b[i];
      valid_in = abuse_vld;
      data_in  = vres;
      tick();
      wr_en    = 1'b0;
      check("no_done_fill", done, 0);
      if (i < 7) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check("go_low_fill", go_out, 0);
        end
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic check_send(input logic [7:0][7:0] b, input logic abuse_wr);
    for (int j = 0; j < 8; j++) begin
      check("go_send", go_out, 1);
      check("d_out_send", d_out, b[j]);
      check("busy_send", busy, 1);
      check("wr_ready_send", wr_ready, 0);
      if (abuse_wr) begin
        wr_en   = 1'b1;
        wr_data = 8'hAA;
      end
      tick();
    end
    wr_en = 1'b0;
    check("go_drop", go_out, 0);
    check("d_out_idle", d_out, 0);
    check("busy_wait", busy, 1);
  endtask

  task automatic run_vec(input vec_t v);
    write_burst(v.b, v.gap, v.abuse_vld, v.res);
    check_send(v.b, v.abuse_wr);
    if (v.dly < 0) begin
      for (int c = 1; c <= T; c++) begin
        tick();
        if (c < T) check("no_early_done", done, 0);
      end
    end else begin
      for (int c = 0; c < v.dly; c++) begin
        tick();
        check("no_done_wait", done, 0);
      end
      valid_in = 1'b1;
      data_in  = v.res;
      tick();
      valid_in = 1'b0;
    end
    check("done", done, 1);
    check("match", match, v.exp_match);
    check("timeout", timeout, v.exp_to);
    check("wr_ready_after", wr_ready, 1);
    check("busy_after", busy, 0);
    valid_in = 1'b1;
    data_in  = v.res ^ 11'd1;
    tick();
    valid_in = 1'b0;
    check("done_one_pulse", done, 0);
    check("match_sticky", match, v.exp_match);
    check("timeout_sticky", timeout, v.exp_to);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; valid_in = 1'b0; data_in = '0;

    vecs[0] = '{b: pack8(5,3,7,8,5,3,2,1), gap: 0, abuse_wr: 0, abuse_vld: 0,
                dly: 0, res: 11'd34, exp_match: 1, exp_to: 0};
    vecs[1] = '{b: pack8(5,3,7,8,5,3,2,1), gap: 0, abuse_wr: 0, abuse_vld: 0,
                dly: 3, res: 11'd35, exp_match: 0, exp_to: 0};
    vecs[2] = '{b: pack8(255,255,255,255,255,255,255,255), gap: 0, abuse_wr: 0, abuse_vld: 0,
                dly: 2, res: 11'd2040, exp_match: 1, exp_to: 0};
    vecs[3] = '{b: pack8(9,8,7,6,5,4,3,2), gap: 0, abuse_wr: 0, abuse_vld: 0,
                dly: T-1, res: 11'd44, exp_match: 1, exp_to: 0};
    vecs[4] = '{b: pack8(8'h11,8'h22,8'h33,8'h44,8'h55,8'h66,8'h77,8'h88), gap: 2,
                abuse_wr: 1, abuse_vld: 1, dly: 5, res: 11'd612, exp_match: 1, exp_to: 0};
    vecs[5] = '{b: pack8(1,2,3,4,5,6,7,8), gap: 0, abuse_wr: 0, abuse_vld: 0,
                dly: -1, res: 11'd36, exp_match: 0, exp_to: 1};

    tick(); tick();
    rst = 1'b0;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_go", go_out, 0);
    check("rst_d_out", d_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_match", match, 0);
    check("rst_timeout", timeout, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset on the 4th SEND cycle aborts the burst with no done.
    write_burst(pack8(1,2,3,4,5,6,7,8), 0, 1'b0, 11'd0);
    check("abort_go", go_out, 1);
    tick(); tick(); tick();
    check("abort_d3", d_out, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_go_low", go_out, 0);
    check("abort_d_out", d_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_match", match, 0);
    check("abort_timeout", timeout, 0);
    check("abort_wr_ready", wr_ready, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("abort_quiet_go", go_out, 0);
      check("abort_quiet_done", done, 0);
    end

    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
